pc_fetch_unit: RTL

- Consumer side of the flush controller: receives jump flag/address and hold, owns the PC register and the IF/ID pipeline register.
- Fetches instructions over a single-outstanding req/ack instruction bus.
- Presents fetched instruction and PC to decode under decode backpressure.
- Redirects on jump and discards any in-flight fetch.

---
 rtl/pc_fetch_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter and the IF/ID pipeline register.
// Issues single-outstanding fetches on a req/ack instruction bus, buffers one
// extra response in a skid entry when decode stalls, and redirects on jump
// while discarding any fetch already in flight.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_flag_in,
   input  logic [31:0] jump_addr_in,
   input  logic        hold_flag_in,
   input  logic        id_stall_in,
   output logic        ibus_req_out,
   output logic [31:0] ibus_addr_out,
   input  logic        ibus_ack_in,
   input  logic [31:0] ibus_rdata_in,
   output logic        id_valid_out,
   output logic [31:0] id_pc_out,
   output logic [31:0] id_inst_out,
   output logic [31:0] pc_out
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] reqAddr_q, reqAddr_d;
   logic        idValid_q, idValid_d;
   logic [31:0] idPc_q, idPc_d;
   logic [31:0] idInst_q, idInst_d;
   logic        skidValid_q, skidValid_d;
   logic [31:0] skidPc_q, skidPc_d;
   logic [31:0] skidInst_q, skidInst_d;

   logic        reqActive;
   logic        ackSeen;
   logic        consume;
   logic [31:0] pcInc;
   logic [31:0] jumpTarget;

   // A request is outstanding in FETCH and DRAIN; an ack outside them is noise.
   always_comb begin
      reqActive  = (state_q == FETCH) || (state_q == DRAIN);
      ackSeen    = ibus_ack_in && reqActive;
      consume    = idValid_q && !id_stall_in;
      pcInc      = pc_q + 32'd4;
      jumpTarget = {jump_addr_in[31:2], 2'b00};
   end

   // Next-state logic: jump beats hold, hold beats the stall/consume handshake.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      reqAddr_d   = reqAddr_q;
      idValid_d   = idValid_q;
      idPc_d      = idPc_q;
      idInst_d    = idInst_q;
      skidValid_d = skidValid_q;
      skidPc_d    = skidPc_q;
      skidInst_d  = skidInst_q;

      if (jump_flag_in) begin
         pc_d        = jumpTarget;
         idValid_d   = 1'b0;
         idPc_d      = 32'd0;
         idInst_d    = NOP_INST;
         skidValid_d = 1'b0;
         skidPc_d    = 32'd0;
         skidInst_d  = NOP_INST;
         case (state_q)
            FETCH, DRAIN: begin
               if (ackSeen) begin
                  state_d   = FETCH;
                  reqAddr_d = jumpTarget;
               end else begin
                  state_d   = DRAIN;
               end
            end
            default: begin
               state_d   = FETCH;
               reqAddr_d = jumpTarget;
            end
         endcase
      end else begin
         if (hold_flag_in) begin
            idValid_d   = 1'b0;
            idPc_d      = 32'd0;
            idInst_d    = NOP_INST;
            skidValid_d = 1'b0;
            skidPc_d    = 32'd0;
            skidInst_d  = NOP_INST;
         end else if (consume) begin
            idValid_d   = 1'b0;
            idPc_d      = 32'd0;
            idInst_d    = NOP_INST;
         end

         case (state_q)
            BOOT: begin
               state_d   = FETCH;
               reqAddr_d = pc_q;
            end
            FETCH: begin
               if (ackSeen) begin
                  pc_d = pcInc;
                  if (hold_flag_in) begin
                     reqAddr_d = pcInc;
                  end else if (!idValid_q || consume) begin
                     idValid_d = 1'b1;
                     idPc_d    = reqAddr_q;
                     idInst_d  = ibus_rdata_in;
                     reqAddr_d = pcInc;
                  end else begin
                     skidValid_d = 1'b1;
                     skidPc_d    = reqAddr_q;
                     skidInst_d  = ibus_rdata_in;
                     state_d     = FULL;
                  end
               end
            end
            FULL: begin
               if (hold_flag_in) begin
                  state_d   = FETCH;
                  reqAddr_d = pc_q;
               end else if (consume) begin
                  idValid_d   = skidValid_q;
                  idPc_d      = skidPc_q;
                  idInst_d    = skidInst_q;
                  skidValid_d = 1'b0;
                  skidPc_d    = 32'd0;
                  skidInst_d  = NOP_INST;
                  state_d     = FETCH;
                  reqAddr_d   = pc_q;
               end
            end
            DRAIN: begin
               if (ackSeen) begin
                  state_d   = FETCH;
                  reqAddr_d = pc_q;
               end
            end
            default: begin
               state_d = BOOT;
            end
         endcase
      end
   end

   // State, PC, request address, IF/ID and skid registers with async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_ADDR;
         reqAddr_q   <= 32'd0;
         idValid_q   <= 1'b0;
         idPc_q      <= 32'd0;
         idInst_q    <= NOP_INST;
         skidValid_q <= 1'b0;
         skidPc_q    <= 32'd0;
         skidInst_q  <= NOP_INST;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         reqAddr_q   <= reqAddr_d;
         idValid_q   <= idValid_d;
         idPc_q      <= idPc_d;
         idInst_q    <= idInst_d;
         skidValid_q <= skidValid_d;
         skidPc_q    <= skidPc_d;
         skidInst_q  <= skidInst_d;
      end
   end

   // All outputs come straight from registers so they are glitch-free.
   always_comb begin
      ibus_req_out  = reqActive;
      ibus_addr_out = reqAddr_q;
      id_valid_out  = idValid_q;
      id_pc_out     = idPc_q;
      id_inst_out   = idInst_q;
      pc_out        = pc_q;
   end

endmodule
